pwm_compare: RTL and testbench
==============================

# pwm_compare

Multi-channel PWM compare stage sitting directly downstream of the free-running `counter` block. It samples the counter's `value` output and produces one registered PWM output per channel by comparing against per-channel duty registers. Duty updates from the bus are double-buffered so they take effect only at a period boundary, which prevents glitched pulses.

## Interface
- `WIDTH`, default 8: width of the counter value and of each duty register.
- `CHANNELS`, default 4: number of PWM outputs, 1..16.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `enable`  in  1  global output enable.
- `counter_value`  in  WIDTH  current value from the upstream up-counting `counter`.
- `write_enable`  in  1  single-cycle duty write strobe.
- `write_channel`  in  $clog2(CHANNELS) (minimum 1)  target channel for the write.
- `write_data`  in  WIDTH  new duty (compare) value.
- `pwm_out`  out  CHANNELS  registered PWM outputs.
- `update_pending`  out  CHANNELS  per channel: shadow written but not yet loaded into active.
- `period_irq`  out  1  one-cycle pulse at each period boundary. Present only with the macro; tied 0 otherwise.

## Operation
- Per-channel registers: `shadow[i]`, `active[i]`, `pending[i]`. One shared register, `prev_value`, holds the previous `counter_value`.
- Period boundary (`wrap`): the cycle in which `counter_value < prev_value`. `prev_value` updates every cycle, regardless of `enable`.
- Writes:
  - With `enable`=1: `shadow[write_channel] <= write_data` and `pending <= 1`.
  - With `enable`=0: `shadow` and `active` both load `write_data` immediately, and `pending <= 0`.
  - Writes to a channel index ≥ CHANNELS are ignored.
- Load on `wrap` (enable=1): every channel with `pending`=1 does `active <= shadow` and `pending <= 0`. The compare in the same cycle uses the newly loaded value.
- Write coinciding with `wrap` on the same channel:
  - The load uses the pre-write shadow.
  - The written value lands in the shadow, and `pending` stays 1 for the next period.
- Compare, registered:
  - `pwm_out[i] <= enable && (counter_value < effective_duty[i])`.
  - `effective_duty` is `shadow` when loading this cycle, else `active`.
- Boundary cases:
  - Duty 0: output always low.
  - Duty > max counter value reached (e.g. > TOP of the upstream counter): output always high.
  - Duty = 2^WIDTH−1 with a full-range counter: high for all values except 2^WIDTH−1.
- Upstream halt: the counter value freezes, no wrap is detected and outputs hold their levels. This is correct behaviour.
- `enable` 1→0: `pwm_out` goes 0 on the next edge. Pending flags are kept and load at the first wrap after re-enable.
- Reset values: `shadow`=0, `active`=0, `pending`=0, `prev_value`=0, `pwm_out`=0, `update_pending`=0, `period_irq`=0.
- Reset mid-period: all duties clear. The first period after reset may be partial; no special handling.

## Timing
- `pwm_out` lags `counter_value` by exactly 1 cycle.
- Write to effect:
  - enable=0: the write is visible in `pwm_out` 2 cycles after the strobe edge.
  - enable=1: it takes effect at the first wrap strictly after the strobe cycle, then the 1-cycle output lag applies.
- `update_pending` is registered. It rises the cycle after the write and falls the cycle after the load.
- `period_irq` is registered. It is high for exactly the cycle after `wrap` and only while `enable`=1.
- No stalls and no backpressure: a write is accepted every cycle.

## Configuration
- Macro `PWM_COMPARE_PERIOD_IRQ_EN`.
  - Defined: the `period_irq` register and logic are built as above.
  - Undefined: the port still exists but is driven constant 0 and no wrap-pulse flop is built.
- Wrap detection and double-buffering are unconditional.

## Test plan
- **Reset:** assert `rst` mid-run with duties nonzero → next cycle `pwm_out`=0 and `update_pending`=0. After release with counter running 0..255, all outputs stay 0.
- **Basic duty:** enable=0, write ch0=64 and ch1=0, then enable=1 with counter 0..255 → ch0 high exactly 64 cycles per 256-cycle period, lagging the counter by 1. ch1 is never high.
- **Double-buffer:** enable=1, ch2 active=100, write 200 at counter=50 → `update_pending[2]`=1. The current period stays at 100 high cycles, the next period has 200. Pending clears the cycle after wrap.
- **Write on wrap:** write ch3=30 in the exact cycle `counter_value` goes 255→0 (pending previously 0) → the period starting now uses the old duty. 30 applies from the following period and `update_pending[3]` stays 1 across the wrap.
- **Upstream TOP=99:** counter 0..99 wrapping, ch0 duty=150 → ch0 constant high. Wrap detected every 100 cycles; with macro, `period_irq` pulses every 100 cycles for 1 cycle.
- **Halt/disable:** freeze `counter_value` at 10 for 20 cycles with duty=20 → ch0 held high, no irq. Then drop `enable` → `pwm_out`=0 the next cycle and irq suppressed.

Source files
------------

// File: rtl/pwm_compare.sv
// pwm_compare: multi-channel registered PWM compare stage fed by an up-counter.
// The period_irq pulse is built only when PWM_COMPARE_PERIOD_IRQ_EN is defined.
module pwm_compare #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [WIDTH-1:0]    counter_value,
  input  logic                write_enable,
  input  logic [CH_W-1:0]     write_channel,
  input  logic [WIDTH-1:0]    write_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] update_pending,
  output logic                period_irq
);

  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic [WIDTH-1:0]    eff_duty [CHANNELS];
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] wr_hit, load;
  logic [WIDTH-1:0]    prev_q;
  logic                wrap;

  // A drop in the counter value marks the start of a new period.
  assign wrap = (counter_value < prev_q);

  // Out-of-range channel indices match no channel and are dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_hit
    assign wr_hit[g] = write_enable && (write_channel == CH_W'(g));
  end

  always_comb begin
    load      = '0;
    pwm_d     = '0;
    pending_d = pending_q;
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      load[i]     = enable && wrap && pending_q[i];
      eff_duty[i] = load[i] ? shadow_q[i] : active_q[i];
      pwm_d[i]    = enable && (counter_value < eff_duty[i]);
      if (load[i]) begin
        active_d[i]  = shadow_q[i];
        pending_d[i] = 1'b0;
      end
      // A write on the load cycle lands after the load, so it waits a period.
      if (wr_hit[i]) begin
        shadow_d[i] = write_data;
        if (enable) begin
          pending_d[i] = 1'b1;
        end else begin
          active_d[i]  = write_data;
          pending_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      pending_q <= '0;
      pwm_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      prev_q    <= counter_value;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_out        = pwm_q;
  assign update_pending = pending_q;

`ifdef PWM_COMPARE_PERIOD_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= enable && wrap;
  end

  assign period_irq = irq_q;
`else
  assign period_irq = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare: directed scenarios plus randomized traffic
// against a cycle-level reference model of the duty double-buffering rules.
module tb_pwm_compare;
  localparam int W  = 8;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [W-1:0]  counter_value = '0;
  logic          write_enable = 1'b0;
  logic [1:0]    write_channel = '0;
  logic [W-1:0]  write_data = '0;
  logic [CH-1:0] pwm_out, update_pending;
  logic          period_irq;

  int checks = 0;
  int failures = 0;

  int          m_shadow [CH];
  int          m_active [CH];
  logic [CH-1:0] m_pend = '0;
  logic [CH-1:0] m_pwm  = '0;
  logic        m_irq = 1'b0;
  int          m_prev = 0;

  int cnt = 0;
  int hi [CH];
  int irq_cnt = 0;
  int exp_irq;

  always #5 clk = ~clk;

  pwm_compare #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .counter_value(counter_value),
    .write_enable(write_enable), .write_channel(write_channel), .write_data(write_data),
    .pwm_out(pwm_out), .update_pending(update_pending), .period_irq(period_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next-state of the model from the inputs presented before the coming edge.
  task automatic model_step();
    bit wrap, ld;
    int duty;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
      m_pend = '0; m_pwm = '0; m_irq = 1'b0; m_prev = 0;
      return;
    end
    wrap = int'(counter_value) < m_prev;
    for (int i = 0; i < CH; i++) begin
      ld = enable && wrap && m_pend[i];
      duty = ld ? m_shadow[i] : m_active[i];
      m_pwm[i] = enable && (int'(counter_value) < duty);
      if (ld) begin
        m_active[i] = m_shadow[i];
        m_pend[i] = 1'b0;
      end
      if (write_enable && int'(write_channel) == i) begin
        m_shadow[i] = int'(write_data);
        if (enable) m_pend[i] = 1'b1;
        else begin
          m_active[i] = int'(write_data);
          m_pend[i] = 1'b0;
        end
      end
    end
`ifdef PWM_COMPARE_PERIOD_IRQ_EN
    m_irq = enable && wrap;
`else
    m_irq = 1'b0;
`endif
    m_prev = int'(counter_value);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("update_pending", 32'(update_pending), 32'(m_pend));
    chk("period_irq", 32'(period_irq), 32'(m_irq));
    for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
    irq_cnt += int'(period_irq);
    write_enable = 1'b0;
  endtask

  task automatic run(input int n, input int top);
    for (int k = 0; k < n; k++) begin
      counter_value = W'(cnt);
      tick();
      cnt = (cnt >= top) ? 0 : cnt + 1;
    end
  endtask

  task automatic goto_val(input int v, input int top);
    run(((v - cnt) + (top + 1)) % (top + 1), top);
  endtask

  task automatic wr(input int ch, input int d);
    write_enable  = 1'b1;
    write_channel = 2'(ch);
    write_data    = W'(d);
  endtask

  task automatic clear_hi();
    for (int i = 0; i < CH; i++) hi[i] = 0;
    irq_cnt = 0;
  endtask

  initial begin
    clear_hi();
`ifdef PWM_COMPARE_PERIOD_IRQ_EN
    exp_irq = 1;
`else
    exp_irq = 0;
`endif
    // reset state
    run(2, 255);
    rst = 1'b0;
    chk("reset_pwm", 32'(pwm_out), 0);
    chk("reset_pending", 32'(update_pending), 0);

    // basic duty with immediate writes while disabled
    wr(0, 64);  run(1, 255);
    wr(1, 0);   run(1, 255);
    wr(2, 100); run(1, 255);
    wr(3, 180); run(1, 255);
    enable = 1'b1;
    goto_val(0, 255);
    run(256, 255);
    clear_hi();
    run(256, 255);
    chk("basic_ch0_high", hi[0], 64);
    chk("basic_ch1_high", hi[1], 0);
    chk("basic_ch2_high", hi[2], 100);
    chk("basic_ch3_high", hi[3], 180);
    goto_val(63, 255);
    run(1, 255);
    chk("lag_cv63", 32'(pwm_out[0]), 1);
    run(1, 255);
    chk("lag_cv64", 32'(pwm_out[0]), 0);

    // double-buffered update while enabled
    goto_val(50, 255);
    clear_hi();
    wr(2, 200);
    run(1, 255);
    chk("db_pending_set", 32'(update_pending[2]), 1);
    run(205, 255);
    chk("db_old_duty_tail", hi[2], 50);
    run(1, 255);
    chk("db_pending_clr", 32'(update_pending[2]), 0);
    chk("db_new_at_wrap", 32'(pwm_out[2]), 1);
    clear_hi();
    run(256, 255);
    chk("db_new_duty", hi[2], 200);

    // write coinciding with the wrap cycle
    goto_val(255, 255);
    run(1, 255);
    wr(3, 30);
    run(1, 255);
    chk("wow_pending_kept", 32'(update_pending[3]), 1);
    chk("wow_old_duty_used", 32'(pwm_out[3]), 1);
    clear_hi();
    run(255, 255);
    chk("wow_old_period", hi[3], 179);
    run(1, 255);
    chk("wow_pending_clr", 32'(update_pending[3]), 0);
    clear_hi();
    run(256, 255);
    chk("wow_new_period", hi[3], 30);

    // upstream counter wrapping at 99, duty above reachable values
    enable = 1'b0;
    wr(0, 150);
    run(1, 255);
    enable = 1'b1;
    cnt = 0;
    run(100, 99);
    clear_hi();
    run(200, 99);
    chk("top99_ch0_high", hi[0], 200);
    chk("top99_irq_count", irq_cnt, 2 * exp_irq);

    // halted counter then disable
    enable = 1'b0;
    wr(0, 20);
    counter_value = W'(10);
    tick();
    enable = 1'b1;
    tick();
    clear_hi();
    for (int k = 0; k < 20; k++) tick();
    chk("halt_ch0_high", hi[0], 20);
    chk("halt_no_irq", irq_cnt, 0);
    enable = 1'b0;
    tick();
    chk("disable_pwm_low", 32'(pwm_out), 0);
    chk("disable_irq_low", 32'(period_irq), 0);

    // reset in the middle of a period with pending updates
    enable = 1'b1;
    cnt = 0;
    wr(1, 77);
    run(10, 255);
    chk("pre_reset_pending", 32'(update_pending[1]), 1);
    rst = 1'b1;
    run(1, 255);
    chk("midreset_pwm", 32'(pwm_out), 0);
    chk("midreset_pending", 32'(update_pending), 0);
    rst = 1'b0;
    cnt = 0;
    clear_hi();
    run(256, 255);
    chk("post_reset_low", hi[0] + hi[1] + hi[2] + hi[3], 0);

    // randomized traffic against the model
    for (int seg = 0; seg < 6; seg++) begin
      int top;
      top = (seg % 2 == 1) ? 255 : int'($urandom_range(20, 200));
      cnt = 0;
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(0, 3) == 0) wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        if ($urandom_range(0, 63) == 0) enable = ~enable;
        if ($urandom_range(0, 31) == 0) begin
          counter_value = W'(cnt);
          tick();
        end else begin
          run(1, top);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
